// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned FWD_W = 2;
    localparam int unsigned CD_W  = 4;

    typedef logic [FWD_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_LD  = 2'b11;

    // Reasons the front of the pipe is held or bubbled this cycle.
    typedef struct packed {
        logic lu;
        logic mdu;
        logic br;
    } hz_cause_t;

    // Countdown reload so the result lands at WB MDU_LAT cycles after EX issue.
    function automatic logic [CD_W-1:0] mdu_reload(input int unsigned lat);
        return CD_W'(lat - 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-register view seen by the hazard controller.
interface hazard_ctrl_unit_if #(
    parameter int unsigned RA_W    = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
);
    logic [NUM_SRC*RA_W-1:0] rs_d;
    logic [RA_W-1:0]         rd_d;
    logic                    regwrite_d;
    logic                    mdu_op_d;
    logic [NUM_SRC*RA_W-1:0] rs_e;
    logic [RA_W-1:0]         rd_e;
    logic                    regwrite_e;
    logic                    isload_e;
    logic                    mdu_start_e;
    logic                    branch_taken_e;
    logic [RA_W-1:0]         rd_m;
    logic                    regwrite_m;
    logic [RA_W-1:0]         rd_w;
    logic                    regwrite_w;
    logic                    isload_w;

    logic [2*NUM_SRC-1:0]    fwd_sel_e;
    logic                    stall_f;
    logic                    stall_d;
    logic                    flush_d;
    logic                    flush_e;
    logic                    mdu_busy;
    logic                    mdu_done;
    logic [CNT_W-1:0]        stall_cnt;
    logic [CNT_W-1:0]        flush_cnt;

    modport master (
        output rs_d, rd_d, regwrite_d, mdu_op_d,
        output rs_e, rd_e, regwrite_e, isload_e, mdu_start_e, branch_taken_e,
        output rd_m, regwrite_m, rd_w, regwrite_w, isload_w,
        input  fwd_sel_e, stall_f, stall_d, flush_d, flush_e,
        input  mdu_busy, mdu_done, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_d, rd_d, regwrite_d, mdu_op_d,
        input  rs_e, rd_e, regwrite_e, isload_e, mdu_start_e, branch_taken_e,
        input  rd_m, regwrite_m, rd_w, regwrite_w, isload_w,
        output fwd_sel_e, stall_f, stall_d, flush_d, flush_e,
        output mdu_busy, mdu_done, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_unit_mdu_scoreboard.sv
// Tracks the single outstanding multi-cycle op: busy destination bits,
// latency countdown, and the WB-arrival pulse.
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W    = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MDU_LAT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue,
    input  logic [RA_W-1:0]         issue_rd,
    input  logic [NUM_SRC*RA_W-1:0] lookup_rs,
    input  logic [RA_W-1:0]         lookup_rd,
    output logic                    rs_busy_c,
    output logic                    rd_busy_c,
    output logic                    mdu_busy,
    output logic                    mdu_done
);

    localparam int unsigned NREG = 1 << RA_W;

    logic [NREG-1:0] busy_vec_q, busy_vec_d;
    logic [CD_W-1:0] cnt_q, cnt_d;
    logic [RA_W-1:0] pend_rd_q, pend_rd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Countdown retires the pending destination on the same edge the done pulse is raised.
    always_comb begin
        busy_vec_d = busy_vec_q;
        cnt_d      = cnt_q;
        pend_rd_d  = pend_rd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CD_W'(1);
            if (cnt_q == CD_W'(1)) begin
                done_d                = 1'b1;
                busy_d                = 1'b0;
                busy_vec_d[pend_rd_q] = 1'b0;
            end
        end
        if (issue) begin
            busy_vec_d[issue_rd] = 1'b1;
            cnt_d                = mdu_reload(MDU_LAT);
            pend_rd_d            = issue_rd;
            busy_d               = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec_q <= '0;
            cnt_q      <= '0;
            pend_rd_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            busy_vec_q <= busy_vec_d;
            cnt_q      <= cnt_d;
            pend_rd_q  <= pend_rd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        rs_busy_c = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (busy_vec_q[lookup_rs[k*RA_W +: RA_W]]) rs_busy_c = 1'b1;
        end
        rd_busy_c = busy_vec_q[lookup_rd];
    end

    assign mdu_busy = busy_q;
    assign mdu_done = done_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: EX forwarding selects, load-use and
// MDU stalls, taken-branch flush, and saturating stall/flush event counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W    = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input logic              clk,
    input logic              rst_n,
    hazard_ctrl_unit_if.slave hz
);

    logic [2*NUM_SRC-1:0] fwd_sel_c;
    hz_cause_t            cause_c;
    logic                 stall_c;
    logic                 issue_c;
    logic                 rs_busy_c;
    logic                 rd_busy_c;
    logic                 mdu_busy;
    logic                 mdu_done;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    // Per-operand bypass: MEM is the newest producer, then WB (ALU or load data).
    always_comb begin
        fwd_sel_c = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            logic [RA_W-1:0] src;
            fwd_sel_t        sel;
            src = hz.rs_e[k*RA_W +: RA_W];
            sel = FWD_RF;
            if (src != '0) begin
                if (hz.regwrite_m && (hz.rd_m == src)) begin
                    sel = FWD_MEM;
                end else if (hz.regwrite_w && (hz.rd_w == src)) begin
                    sel = hz.isload_w ? FWD_LD : FWD_WB;
                end
            end
            fwd_sel_c[2*k +: 2] = sel;
        end
    end

    assign issue_c = hz.mdu_start_e && !hz.branch_taken_e && (hz.rd_e != '0);

    mdu_scoreboard #(
        .RA_W    (RA_W),
        .NUM_SRC (NUM_SRC),
        .MDU_LAT (MDU_LAT)
    ) u_mdu_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue_c),
        .issue_rd  (hz.rd_e),
        .lookup_rs (hz.rs_d),
        .lookup_rd (hz.rd_d),
        .rs_busy_c (rs_busy_c),
        .rd_busy_c (rd_busy_c),
        .mdu_busy  (mdu_busy),
        .mdu_done  (mdu_done)
    );

    // A taken branch makes the ID instruction wrong-path, so it overrides any stall.
    always_comb begin
        cause_c     = '0;
        cause_c.br  = hz.branch_taken_e;
        cause_c.mdu = rs_busy_c || (hz.regwrite_d && rd_busy_c) || (hz.mdu_op_d && mdu_busy);
        if (hz.isload_e && hz.regwrite_e && (hz.rd_e != '0)) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (hz.rs_d[k*RA_W +: RA_W] == hz.rd_e) cause_c.lu = 1'b1;
            end
        end
        stall_c = (cause_c.lu || cause_c.mdu) && !cause_c.br;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (cause_c.br && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.fwd_sel_e = fwd_sel_c;
    assign hz.stall_f   = stall_c;
    assign hz.stall_d   = stall_c;
    assign hz.flush_d   = cause_c.br;
    assign hz.flush_e   = stall_c || cause_c.br;
    assign hz.mdu_busy  = mdu_busy;
    assign hz.mdu_done  = mdu_done;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed and randomized bench for hazard_ctrl_unit against a cycle-indexed reference model.
module tb_hazard_ctrl_unit;

    localparam int unsigned RA_W    = 5;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned MDU_LAT = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.RA_W(RA_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) hz ();

    hazard_ctrl_unit #(
        .RA_W(RA_W), .NUM_SRC(NUM_SRC), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // stimulus
    int rs_d_a [NUM_SRC];
    int rs_e_a [NUM_SRC];
    int rd_d, rd_e, rd_m, rd_w;
    bit regwrite_d, mdu_op_d, regwrite_e, isload_e, mdu_start_e, branch;
    bit regwrite_m, regwrite_w, isload_w;

    // reference model: edges since reset, and the issue edge of the pending MDU op
    int edges = 0;
    bit have_issue = 0;
    int issue_edge = 0;
    int issue_rd = 0;
    int exp_scnt = 0;
    int exp_fcnt = 0;
    bit exp_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        return have_issue && ((edges - issue_edge) < int'(MDU_LAT) - 1);
    endfunction

    function automatic bit m_done();
        return have_issue && ((edges - issue_edge) == int'(MDU_LAT) - 1);
    endfunction

    task automatic apply();
        for (int k = 0; k < NUM_SRC; k++) begin
            hz.rs_d[k*RA_W +: RA_W] = RA_W'(rs_d_a[k]);
            hz.rs_e[k*RA_W +: RA_W] = RA_W'(rs_e_a[k]);
        end
        hz.rd_d = RA_W'(rd_d);  hz.regwrite_d = regwrite_d;  hz.mdu_op_d = mdu_op_d;
        hz.rd_e = RA_W'(rd_e);  hz.regwrite_e = regwrite_e;  hz.isload_e = isload_e;
        hz.mdu_start_e = mdu_start_e;  hz.branch_taken_e = branch;
        hz.rd_m = RA_W'(rd_m);  hz.regwrite_m = regwrite_m;
        hz.rd_w = RA_W'(rd_w);  hz.regwrite_w = regwrite_w;  hz.isload_w = isload_w;
    endtask

    task automatic clear_in();
        for (int k = 0; k < NUM_SRC; k++) begin
            rs_d_a[k] = 0;
            rs_e_a[k] = 0;
        end
        rd_d = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        regwrite_d = 0; mdu_op_d = 0; regwrite_e = 0; isload_e = 0; mdu_start_e = 0;
        branch = 0; regwrite_m = 0; regwrite_w = 0; isload_w = 0;
        apply();
    endtask

    task automatic rand_in(input bit allow_mdu);
        for (int k = 0; k < NUM_SRC; k++) begin
            rs_d_a[k] = $urandom_range(0, 3);
            rs_e_a[k] = $urandom_range(0, 3);
        end
        rd_d = $urandom_range(0, 3); rd_e = $urandom_range(0, 3);
        rd_m = $urandom_range(0, 3); rd_w = $urandom_range(0, 3);
        regwrite_d = 1'($urandom_range(0, 1));
        mdu_op_d   = ($urandom_range(0, 3) == 0);
        regwrite_e = 1'($urandom_range(0, 1));
        isload_e   = ($urandom_range(0, 2) == 0);
        branch     = ($urandom_range(0, 7) == 0);
        regwrite_m = 1'($urandom_range(0, 1));
        regwrite_w = 1'($urandom_range(0, 1));
        isload_w   = 1'($urandom_range(0, 1));
        mdu_start_e = allow_mdu && !m_busy() && ($urandom_range(0, 3) == 0);
        apply();
    endtask

    // Called at a falling edge with inputs applied; compares every output.
    task automatic eval_check(input string tag);
        logic [2*NUM_SRC-1:0] ef;
        bit lu, ms;
        #1;
        lu = 0;
        ms = 0;
        ef = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int f;
            if (isload_e && regwrite_e && rd_e != 0 && rd_e == rs_d_a[k]) lu = 1;
            if (m_busy() && rs_d_a[k] == issue_rd) ms = 1;
            f = 0;
            if (rs_e_a[k] != 0) begin
                if (regwrite_m && rd_m == rs_e_a[k]) f = 2;
                else if (regwrite_w && rd_w == rs_e_a[k]) f = isload_w ? 3 : 1;
            end
            ef[2*k +: 2] = 2'(f);
        end
        if (m_busy() && ((regwrite_d && rd_d == issue_rd) || mdu_op_d)) ms = 1;
        exp_stall = (lu || ms) && !branch;
        check({tag, ".fwd_sel_e"}, 32'(hz.fwd_sel_e), 32'(ef));
        check({tag, ".stall_f"},   32'(hz.stall_f),   32'(exp_stall));
        check({tag, ".stall_d"},   32'(hz.stall_d),   32'(exp_stall));
        check({tag, ".flush_d"},   32'(hz.flush_d),   32'(branch));
        check({tag, ".flush_e"},   32'(hz.flush_e),   32'(exp_stall || branch));
        check({tag, ".mdu_busy"},  32'(hz.mdu_busy),  32'(m_busy()));
        check({tag, ".mdu_done"},  32'(hz.mdu_done),  32'(m_done()));
        check({tag, ".stall_cnt"}, 32'(hz.stall_cnt), 32'(exp_scnt));
        check({tag, ".flush_cnt"}, 32'(hz.flush_cnt), 32'(exp_fcnt));
        if (mdu_start_e) check({tag, ".start_while_busy"}, 32'(hz.mdu_busy), 32'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        edges++;
        if (exp_stall && exp_scnt < CNT_MAX) exp_scnt++;
        if (branch && exp_fcnt < CNT_MAX) exp_fcnt++;
        if (mdu_start_e && !branch && rd_e != 0) begin
            have_issue = 1;
            issue_edge = edges;
            issue_rd   = rd_e;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        edges = 0; have_issue = 0; issue_edge = 0; issue_rd = 0;
        exp_scnt = 0; exp_fcnt = 0; exp_stall = 0;
    endtask

    initial begin
        clear_in();
        model_reset();
        #12;
        check("rst.fwd_sel_e", 32'(hz.fwd_sel_e), 32'd0);
        check("rst.stall_d",   32'(hz.stall_d),   32'd0);
        check("rst.flush_e",   32'(hz.flush_e),   32'd0);
        check("rst.mdu_busy",  32'(hz.mdu_busy),  32'd0);
        check("rst.mdu_done",  32'(hz.mdu_done),  32'd0);
        check("rst.stall_cnt", 32'(hz.stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MEM beats WB for the same register; r0 never forwards
        rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1; rs_e_a[0] = 5; apply();
        eval_check("t1_mem");
        check("t1_mem.sel0", 32'(hz.fwd_sel_e[1:0]), 32'b10);
        advance();
        rd_m = 0; rd_w = 0; rs_e_a[0] = 0; apply();
        eval_check("t1_r0");
        check("t1_r0.sel0", 32'(hz.fwd_sel_e[1:0]), 32'b00);
        advance();

        // WB load data versus WB ALU result on operand 1
        clear_in(); isload_w = 1; rd_w = 7; regwrite_w = 1; rs_e_a[1] = 7; apply();
        eval_check("t2_ld");
        check("t2_ld.sel1", 32'(hz.fwd_sel_e[3:2]), 32'b11);
        advance();
        isload_w = 0; apply();
        eval_check("t2_wb");
        check("t2_wb.sel1", 32'(hz.fwd_sel_e[3:2]), 32'b01);
        advance();

        // load-use stall for one cycle
        clear_in(); isload_e = 1; regwrite_e = 1; rd_e = 3; rs_d_a[0] = 3; apply();
        eval_check("t3_lu");
        check("t3_lu.stall_d", 32'(hz.stall_d), 32'd1);
        advance();
        clear_in();
        eval_check("t3_after");
        check("t3_after.stall_cnt", 32'(hz.stall_cnt), 32'd1);
        advance();

        // MDU issue to r9, dependent instruction waits in ID until the result reaches WB
        clear_in(); mdu_start_e = 1; regwrite_e = 1; rd_e = 9; apply();
        eval_check("t4_issue");
        advance();
        clear_in(); rs_d_a[0] = 9; apply();
        for (int i = 0; i < 4; i++) begin
            eval_check($sformatf("t4_wait%0d", i));
            check($sformatf("t4_wait%0d.busy", i), 32'(hz.mdu_busy), 32'(i < 3));
            check($sformatf("t4_wait%0d.done", i), 32'(hz.mdu_done), 32'(i == 3));
            check($sformatf("t4_wait%0d.stall", i), 32'(hz.stall_d), 32'(i < 3));
            advance();
        end

        // taken branch overrides load-use stall
        clear_in(); isload_e = 1; regwrite_e = 1; rd_e = 3; rs_d_a[0] = 3; branch = 1; apply();
        eval_check("t5_br");
        check("t5_br.flush_d", 32'(hz.flush_d), 32'd1);
        check("t5_br.stall_d", 32'(hz.stall_d), 32'd0);
        advance();
        clear_in();
        eval_check("t5_after");
        check("t5_after.flush_cnt", 32'(hz.flush_cnt), 32'd1);
        advance();

        // random traffic, saturating both narrow counters
        for (int i = 0; i < 300; i++) begin
            rand_in(1'b1);
            eval_check($sformatf("rnd%0d", i));
            advance();
        end

        // reset in the middle of an MDU countdown
        clear_in(); mdu_start_e = 1; regwrite_e = 1; rd_e = 2; apply();
        eval_check("t6_issue");
        advance();
        clear_in();
        eval_check("t6_busy");
        advance();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst.mdu_busy",  32'(hz.mdu_busy),  32'd0);
        check("t6_rst.stall_cnt", 32'(hz.stall_cnt), 32'd0);
        check("t6_rst.flush_cnt", 32'(hz.flush_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < MDU_LAT + 1; i++) begin
            eval_check($sformatf("t6_post%0d", i));
            check($sformatf("t6_post%0d.done", i), 32'(hz.mdu_done), 32'd0);
            advance();
        end

        for (int i = 0; i < 100; i++) begin
            rand_in(1'b1);
            eval_check($sformatf("rnd2_%0d", i));
            advance();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
